muldiv_unit: RTL and testbench

Iterative multiply/divide unit with architectural HI/LO registers. It sits directly downstream of the control path and consumes its Mul, Div and Unsigned decode outputs, with operands taken from register-file read ports 0/1. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. It exposes busy so the control path can hold the PC while an operation is in flight.

---
 rtl/muldiv_unit.sv | 163 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// One result bit per cycle; shift-add multiply, restoring divide.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mul,
    input  logic             start_div,
    input  logic             is_unsigned,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_mul_q, is_mul_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic               dbz_q, dbz_d;
    logic               done_q, done_d;
    logic               dbzo_q, dbzo_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_part;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] mul_step;
    logic [2*WIDTH-1:0] div_step;
    logic [2*WIDTH-1:0] prod_neg;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Operand magnitudes and one iteration of each datapath.
    always_comb begin
        a_neg    = !is_unsigned && op_a[WIDTH-1];
        b_neg    = !is_unsigned && op_b[WIDTH-1];
        a_mag    = a_neg ? (~op_a + 1'b1) : op_a;
        b_mag    = b_neg ? (~op_b + 1'b1) : op_b;
        mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                 + {1'b0, (prod_q[0] ? b_q : {WIDTH{1'b0}})};
        mul_step = {mul_sum, prod_q[WIDTH-1:1]};
        div_part = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
        div_diff = div_part - {1'b0, b_q};
        div_step = {(div_diff[WIDTH] ? div_part[WIDTH-1:0]
                                     : div_diff[WIDTH-1:0]),
                    prod_q[WIDTH-2:0], ~div_diff[WIDTH]};
        prod_neg = ~prod_q + 1'b1;
        quo_fix  = neg_q ? (~prod_q[WIDTH-1:0] + 1'b1)
                         : prod_q[WIDTH-1:0];
        rem_fix  = rneg_q ? (~prod_q[2*WIDTH-1:WIDTH] + 1'b1)
                          : prod_q[2*WIDTH-1:WIDTH];
    end

    // Next-state logic for the IDLE/RUN/FIX sequencer and HI/LO.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_mul_d = is_mul_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dbz_d    = dbz_q;
        b_d      = b_q;
        prod_d   = prod_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dbzo_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_mul || start_div) begin
                    is_mul_d = start_mul;
                    neg_d    = a_neg ^ b_neg;
                    rneg_d   = a_neg;
                    b_d      = b_mag;
                    prod_d   = {{WIDTH{1'b0}}, a_mag};
                    cnt_d    = '0;
                    dbz_d    = !start_mul && (op_b == '0);
                    state_d  = (!start_mul && (op_b == '0)) ? FIX : RUN;
                end else begin
                    if (mthi) hi_d = wr_data;
                    if (mtlo) lo_d = wr_data;
                end
            end
            RUN: begin
                prod_d = is_mul_q ? mul_step : div_step;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                dbzo_d  = dbz_q;
                if (!dbz_q) begin
                    if (is_mul_q) begin
                        {hi_d, lo_d} = neg_q ? prod_neg : prod_q;
                    end else begin
                        lo_d = quo_fix;
                        hi_d = rem_fix;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_mul_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dbz_q    <= 1'b0;
            done_q   <= 1'b0;
            dbzo_q   <= 1'b0;
            b_q      <= '0;
            prod_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_mul_q <= is_mul_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dbz_q    <= dbz_d;
            done_q   <= done_d;
            dbzo_q   <= dbzo_d;
            b_q      <= b_d;
            prod_q   <= prod_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign div_by_zero = dbzo_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
// Hand-computed results, latencies and pulse counts.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_mul, start_div, is_unsigned;
    logic [31:0] op_a, op_b, wr_data;
    logic        mthi, mtlo;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .start_mul(start_mul), .start_div(start_div),
        .is_unsigned(is_unsigned),
        .op_a(op_a), .op_b(op_b),
        .mthi(mthi), .mtlo(mtlo), .wr_data(wr_data),
        .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one request, then observe 40 cycles (bounded).
    task automatic run_op(input logic sm, input logic sd,
                          input logic uns,
                          input logic [31:0] a, input logic [31:0] b,
                          input int inj,
                          output int nbusy, output int ndone,
                          output int ndbz, output int done_at);
        @(negedge clk);
        start_mul = sm; start_div = sd; is_unsigned = uns;
        op_a = a; op_b = b;
        @(negedge clk);
        start_mul = 0; start_div = 0;
        nbusy = 0; ndone = 0; ndbz = 0; done_at = -1;
        for (int i = 1; i <= 40; i++) begin
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                if (done_at < 0) done_at = i;
            end
            if (div_by_zero) ndbz++;
            if (i == inj) begin
                start_mul = 1; is_unsigned = 1;
                op_a = 32'd2; op_b = 32'd3;
                mthi = 1; mtlo = 1; wr_data = 32'hABCD;
            end else if (i == inj + 1) begin
                start_mul = 0; mthi = 0; mtlo = 0;
            end
            @(negedge clk);
        end
    endtask

    int nb, nd, nz, da;

    initial begin
        reset = 1; start_mul = 0; start_div = 0; is_unsigned = 0;
        op_a = 0; op_b = 0; mthi = 0; mtlo = 0; wr_data = 0;
        repeat (2) @(negedge clk);
        reset = 0;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dbz", 64'(div_by_zero), 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);

        run_op(1, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, nb, nd, nz, da);
        chk("multu_res", {hi, lo}, 64'hFFFFFFFE_00000001);
        chk("multu_busy", 64'(nb), 64'd33);
        chk("multu_ndone", 64'(nd), 64'd1);
        chk("multu_done_at", 64'(da), 64'd34);

        run_op(1, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, nb, nd, nz, da);
        chk("mult_m1m1", {hi, lo}, 64'h00000000_00000001);

        run_op(1, 0, 0, 32'hFFFFFFF9, 32'd3, 0, nb, nd, nz, da);
        chk("mult_m7x3", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);

        run_op(0, 1, 0, 32'hFFFFFFF9, 32'd2, 0, nb, nd, nz, da);
        chk("div_m7d2", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        chk("div_dbz", 64'(nz), 64'd0);
        chk("div_busy", 64'(nb), 64'd33);

        run_op(0, 1, 1, 32'd100, 32'd7, 0, nb, nd, nz, da);
        chk("divu_100_7", {hi, lo}, {32'd2, 32'd14});
        chk("divu_dbz", 64'(nz), 64'd0);

        run_op(0, 1, 0, 32'h80000000, 32'hFFFFFFFF, 0, nb, nd, nz, da);
        chk("div_ovf", {hi, lo}, 64'h00000000_80000000);

        run_op(0, 1, 0, 32'h00000007, 32'hFFFFFFFE, 0, nb, nd, nz, da);
        chk("div_7dm2", {hi, lo}, 64'h00000001_FFFFFFFD);

        run_op(1, 1, 1, 32'd6, 32'd7, 0, nb, nd, nz, da);
        chk("both_start", {hi, lo}, {32'd0, 32'd42});

        @(negedge clk);
        mtlo = 1; wr_data = 32'h1234;
        @(negedge clk);
        mtlo = 0;
        chk("mtlo", 64'(lo), 64'h1234);
        mthi = 1; wr_data = 32'h5678;
        @(negedge clk);
        mthi = 0;
        chk("mthi", {hi, lo}, {32'h5678, 32'h1234});

        run_op(0, 1, 0, 32'd99, 32'd0, 0, nb, nd, nz, da);
        chk("dbz_hilo", {hi, lo}, {32'h5678, 32'h1234});
        chk("dbz_busy", 64'(nb), 64'd1);
        chk("dbz_ndone", 64'(nd), 64'd1);
        chk("dbz_ndbz", 64'(nz), 64'd1);
        chk("dbz_done_at", 64'(da), 64'd2);

        run_op(1, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, nb, nd, nz, da);
        chk("midrun_res", {hi, lo}, 64'hFFFFFFFE_00000001);
        chk("midrun_busy", 64'(nb), 64'd33);
        chk("midrun_ndone", 64'(nd), 64'd1);

        @(negedge clk);
        start_mul = 1; is_unsigned = 1; op_a = 32'd4; op_b = 32'd5;
        mthi = 1; wr_data = 32'hDEAD;
        @(negedge clk);
        start_mul = 0; mthi = 0;
        repeat (40) @(negedge clk);
        chk("start_vs_mthi", {hi, lo}, {32'd0, 32'd20});

        @(negedge clk);
        mthi = 1; mtlo = 1; wr_data = 32'h77;
        @(negedge clk);
        mthi = 0; mtlo = 0;
        chk("mt_both", {hi, lo}, {32'h77, 32'h77});

        @(negedge clk);
        start_div = 1; is_unsigned = 1; op_a = 32'd1000; op_b = 32'd3;
        @(negedge clk);
        start_div = 0;
        repeat (9) @(negedge clk);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_hilo", {hi, lo}, 64'd0);

        run_op(1, 0, 1, 32'd3, 32'd5, 0, nb, nd, nz, da);
        chk("post_rst_mul", {hi, lo}, {32'd0, 32'd15});
        chk("post_rst_ndone", 64'(nd), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
